// File: rtl/dcache_fill_controller_pkg.sv
// Shared definitions for the direct-mapped data cache fill controller:
// FSM state encoding, CPU address field layout and a block byte-select helper.
package dcache_fill_controller_pkg;

  localparam int TAG_W  = 3;
  localparam int IDX_W  = 3;
  localparam int OFF_W  = 2;
  localparam int ADDR_W = TAG_W + IDX_W + OFF_W;
  localparam int BLK_W  = 32;

  localparam int OFF_LSB = 0;
  localparam int IDX_LSB = OFF_W;
  localparam int TAG_LSB = OFF_W + IDX_W;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WRITEBACK = 2'd1;
  localparam logic [1:0] ST_FETCH     = 2'd2;
  localparam logic [1:0] ST_UPDATE    = 2'd3;

  function automatic logic [7:0] block_byte(input logic [BLK_W-1:0] blk,
                                            input logic [OFF_W-1:0] off);
    return blk[{off, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/dcache_fill_controller_cache_line_store.sv
// Valid/dirty/tag/data arrays of the data cache. Valid and dirty clear
// asynchronously; one write port (byte store or whole-block fill), combinational read.
module cache_line_store
  import dcache_fill_controller_pkg::*;
#(
  parameter int NBLOCKS = 8,
  parameter int TAGW    = 3,
  parameter int IDXW    = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [IDXW-1:0]   idx,
  output logic              rd_valid,
  output logic              rd_dirty,
  output logic [TAGW-1:0]   rd_tag,
  output logic [BLK_W-1:0]  rd_data,
  input  logic              byte_we,
  input  logic [OFF_W-1:0]  byte_off,
  input  logic [7:0]        byte_data,
  input  logic              fill_we,
  input  logic [TAGW-1:0]   fill_tag,
  input  logic [BLK_W-1:0]  fill_data
);

  logic [NBLOCKS-1:0] valid_q, valid_d;
  logic [NBLOCKS-1:0] dirty_q, dirty_d;
  logic [TAGW-1:0]    tag_mem  [NBLOCKS];
  logic [BLK_W-1:0]   data_mem [NBLOCKS];

  // A fill always leaves the line clean; a store to a resident line marks it dirty.
  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    if (fill_we) begin
      valid_d[idx] = 1'b1;
      dirty_d[idx] = 1'b0;
    end else if (byte_we) begin
      dirty_d[idx] = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  always_ff @(posedge clock) begin
    if (fill_we) begin
      tag_mem[idx]  <= fill_tag;
      data_mem[idx] <= fill_data;
    end else if (byte_we) begin
      data_mem[idx][{byte_off, 3'b000} +: 8] <= byte_data;
    end
  end

  assign rd_valid = valid_q[idx];
  assign rd_dirty = dirty_q[idx];
  assign rd_tag   = tag_mem[idx];
  assign rd_data  = data_mem[idx];

endmodule

// File: rtl/dcache_fill_controller.sv
// Write-back, write-allocate controller for the direct-mapped data cache:
// same-cycle hits, dirty-victim write-back, block fetch and line update.
module dcache_fill_controller
  import dcache_fill_controller_pkg::*;
#(
  parameter int NBLOCKS = 8,
  parameter int TAGW    = 3,
  localparam int IDXW   = $clog2(NBLOCKS),
  localparam int ADDRW  = TAGW + IDXW + OFF_W
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 read,
  input  logic                 write,
  input  logic [ADDRW-1:0]     address,
  input  logic [7:0]           writedata,
  output logic [7:0]           readdata,
  output logic                 busywait,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [TAGW+IDXW-1:0] mem_address,
  output logic [BLK_W-1:0]     mem_writedata,
  input  logic [BLK_W-1:0]     mem_readdata,
  input  logic                 mem_busywait
);

  state_t state_q, state_d;

  logic [TAGW-1:0]  a_tag;
  logic [IDXW-1:0]  a_idx;
  logic [OFF_W-1:0] a_off;
  logic             rd_valid, rd_dirty;
  logic [TAGW-1:0]  rd_tag;
  logic [BLK_W-1:0] rd_data;
  logic             hit, req, byte_we, fill_we;

  assign a_tag = address[IDXW + OFF_W +: TAGW];
  assign a_idx = address[OFF_W +: IDXW];
  assign a_off = address[OFF_W-1:0];

  cache_line_store #(
    .NBLOCKS (NBLOCKS),
    .TAGW    (TAGW),
    .IDXW    (IDXW)
  ) u_store (
    .clock     (clock),
    .reset     (reset),
    .idx       (a_idx),
    .rd_valid  (rd_valid),
    .rd_dirty  (rd_dirty),
    .rd_tag    (rd_tag),
    .rd_data   (rd_data),
    .byte_we   (byte_we),
    .byte_off  (a_off),
    .byte_data (writedata),
    .fill_we   (fill_we),
    .fill_tag  (a_tag),
    .fill_data (mem_readdata)
  );

  assign hit = rd_valid && (rd_tag == a_tag);
  assign req = read || write;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req && !hit) state_d = (rd_valid && rd_dirty) ? ST_WRITEBACK : ST_FETCH;
      end
      ST_WRITEBACK: if (!mem_busywait) state_d = ST_FETCH;
      ST_FETCH:     if (!mem_busywait) state_d = ST_UPDATE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // CPU-side outputs are masked by reset so a held request cannot stall or store during it.
  always_comb begin
    byte_we  = reset && (state_q == ST_IDLE) && write && hit;
    fill_we  = (state_q == ST_UPDATE);
    busywait = reset && ((state_q != ST_IDLE) || (req && !hit));
    readdata = '0;
    if (reset && (state_q == ST_IDLE) && read && !write && hit)
      readdata = block_byte(rd_data, a_off);
  end

  // Memory strobes decode only registered state, so they never glitch or overlap.
  always_comb begin
    mem_read      = (state_q == ST_FETCH);
    mem_write     = (state_q == ST_WRITEBACK);
    mem_address   = '0;
    mem_writedata = '0;
    if (state_q == ST_WRITEBACK) begin
      mem_address   = {rd_tag, a_idx};
      mem_writedata = rd_data;
    end else if (state_q == ST_FETCH) begin
      mem_address   = {a_tag, a_idx};
    end
  end

endmodule
